// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and a saturating stall counter.
// A load in EX whose destination feeds the ID instruction freezes PC and IF/ID and bubbles EX.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              id_memwrite,
    input  logic              id_memtoreg,
    input  logic              id_alusrc,
    input  logic              id_regdst,
    input  logic [3:0]        id_aluop,
    input  logic              flush,
    input  logic              perf_clr,
    output logic              ex_valid,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_rd,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic              ex_regwrite,
    output logic              ex_memread,
    output logic              ex_memwrite,
    output logic              ex_memtoreg,
    output logic              ex_alusrc,
    output logic              ex_regdst,
    output logic [3:0]        ex_aluop,
    output logic [REG_AW-1:0] ex_wreg,
    output logic              stall,
    output logic              pc_write_en,
    output logic              ifid_write_en,
    output logic [CNT_W-1:0]  stall_count
);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
        logic              regwrite;
        logic              memread;
        logic              memwrite;
        logic              memtoreg;
        logic              alusrc;
        logic              regdst;
        logic [3:0]        aluop;
    } ex_fields_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + 1'b1;
    endfunction

    ex_fields_t       ex_q, ex_d, id_fields;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hazard;
    logic             rs_match, rt_match;

    always_comb begin
        id_fields          = '0;
        id_fields.valid    = id_valid;
        id_fields.rs       = id_rs;
        id_fields.rt       = id_rt;
        id_fields.rd       = id_rd;
        id_fields.rs_data  = id_rs_data;
        id_fields.rt_data  = id_rt_data;
        id_fields.imm      = id_imm;
        // An invalid ID slot must never produce side effects downstream.
        id_fields.regwrite = id_regwrite & id_valid;
        id_fields.memread  = id_memread  & id_valid;
        id_fields.memwrite = id_memwrite & id_valid;
        id_fields.memtoreg = id_memtoreg & id_valid;
        id_fields.alusrc   = id_alusrc   & id_valid;
        id_fields.regdst   = id_regdst   & id_valid;
        id_fields.aluop    = id_aluop & {4{id_valid}};
    end

    always_comb begin
        ex_wreg  = ex_q.regdst ? ex_q.rd : ex_q.rt;
        rs_match = id_uses_rs & (id_rs == ex_wreg);
        rt_match = id_uses_rt & (id_rt == ex_wreg);
        hazard   = ex_q.valid & ex_q.memread & (ex_wreg != '0) & id_valid & (rs_match | rt_match);
        // Flush discards the ID instruction, so there is nothing left to stall for.
        stall         = hazard & ~flush & rst_n;
        pc_write_en   = ~stall;
        ifid_write_en = ~stall;
    end

    always_comb begin
        ex_d = id_fields;
        if (flush || hazard) begin
            ex_d = '0;
        end
        cnt_d = cnt_q;
        if (perf_clr) begin
            cnt_d = '0;
        end else if (stall) begin
            cnt_d = sat_inc(cnt_q);
        end
    end

    // ID -> EX stage boundary
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q  <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            cnt_q <= cnt_d;
        end
    end

    assign ex_valid    = ex_q.valid;
    assign ex_rs       = ex_q.rs;
    assign ex_rt       = ex_q.rt;
    assign ex_rd       = ex_q.rd;
    assign ex_rs_data  = ex_q.rs_data;
    assign ex_rt_data  = ex_q.rt_data;
    assign ex_imm      = ex_q.imm;
    assign ex_regwrite = ex_q.regwrite;
    assign ex_memread  = ex_q.memread;
    assign ex_memwrite = ex_q.memwrite;
    assign ex_memtoreg = ex_q.memtoreg;
    assign ex_alusrc   = ex_q.alusrc;
    assign ex_regdst   = ex_q.regdst;
    assign ex_aluop    = ex_q.aluop;
    assign stall_count = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a reference model predicts each EX update into a
// scoreboard queue, which is popped and compared after the clock edge.
module tb_id_ex_stage;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 4;

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] rs, rt, rd;
        logic [DW-1:0] rsd, rtd, imm;
        logic          rw, mr, mw, mtr, as, rdst;
        logic [3:0]    op;
        logic [CW-1:0] cnt;
    } snap_t;

    logic          clk = 1'b0;
    logic          rst_n, id_valid, id_uses_rs, id_uses_rt, flush, perf_clr;
    logic [AW-1:0] id_rs, id_rt, id_rd;
    logic [DW-1:0] id_rs_data, id_rt_data, id_imm;
    logic          id_regwrite, id_memread, id_memwrite, id_memtoreg, id_alusrc, id_regdst;
    logic [3:0]    id_aluop;

    logic          ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc, ex_regdst;
    logic [AW-1:0] ex_rs, ex_rt, ex_rd, ex_wreg;
    logic [DW-1:0] ex_rs_data, ex_rt_data, ex_imm;
    logic [3:0]    ex_aluop;
    logic          stall, pc_write_en, ifid_write_en;
    logic [CW-1:0] stall_count;

    int    total = 0;
    int    bad   = 0;
    snap_t sb[$];
    snap_t m;
    logic  last_stall;
    logic [CW-1:0] cnt_before;

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
        .id_memtoreg(id_memtoreg), .id_alusrc(id_alusrc), .id_regdst(id_regdst),
        .id_aluop(id_aluop), .flush(flush), .perf_clr(perf_clr),
        .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
        .ex_memtoreg(ex_memtoreg), .ex_alusrc(ex_alusrc), .ex_regdst(ex_regdst),
        .ex_aluop(ex_aluop), .ex_wreg(ex_wreg), .stall(stall),
        .pc_write_en(pc_write_en), .ifid_write_en(ifid_write_en), .stall_count(stall_count)
    );

    task automatic check(input string tag, input logic [159:0] act, input logic [159:0] exp);
        total++;
        assert (act === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, act, exp);
        end
    endtask

    // Load an instruction into the ID-side inputs; data fields are random.
    task automatic instr(input logic v, input logic [AW-1:0] rs, rt, rd, input logic urs, urt,
                         input logic rw, mr, mw, mtr, as, rdst, input logic [3:0] op);
        id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
        id_uses_rs = urs; id_uses_rt = urt;
        id_regwrite = rw; id_memread = mr; id_memwrite = mw;
        id_memtoreg = mtr; id_alusrc = as; id_regdst = rdst; id_aluop = op;
        id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
    endtask

    task automatic step();
        logic [AW-1:0] wreg;
        logic  haz, exp_stall;
        snap_t nxt, got;
        #3;
        wreg = m.rdst ? m.rd : m.rt;
        haz = 1'b0;
        if (m.valid && m.mr && wreg != 0 && id_valid) begin
            if ((id_uses_rs && id_rs == wreg) || (id_uses_rt && id_rt == wreg)) haz = 1'b1;
        end
        exp_stall = haz && !flush && rst_n;
        check("stall", {159'd0, stall}, {159'd0, exp_stall});
        check("pc_write_en", {159'd0, pc_write_en}, {159'd0, !exp_stall});
        check("ifid_write_en", {159'd0, ifid_write_en}, {159'd0, !exp_stall});
        check("ex_wreg", {155'd0, ex_wreg}, {155'd0, wreg});
        last_stall = stall;
        nxt = '0;
        if (rst_n) begin
            if (!flush && !haz) begin
                nxt.valid = id_valid;
                nxt.rs = id_rs; nxt.rt = id_rt; nxt.rd = id_rd;
                nxt.rsd = id_rs_data; nxt.rtd = id_rt_data; nxt.imm = id_imm;
                if (id_valid) begin
                    nxt.rw = id_regwrite; nxt.mr = id_memread; nxt.mw = id_memwrite;
                    nxt.mtr = id_memtoreg; nxt.as = id_alusrc; nxt.rdst = id_regdst;
                    nxt.op = id_aluop;
                end
            end
            if (perf_clr) nxt.cnt = '0;
            else if (exp_stall && m.cnt != 4'hF) nxt.cnt = m.cnt + 1'b1;
            else nxt.cnt = m.cnt;
        end
        sb.push_back(nxt);
        @(posedge clk);
        #1;
        got = {ex_valid, ex_rs, ex_rt, ex_rd, ex_rs_data, ex_rt_data, ex_imm,
               ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc, ex_regdst,
               ex_aluop, stall_count};
        nxt = sb.pop_front();
        check("ex_state", {29'd0, got}, {29'd0, nxt});
        m = nxt;
    endtask

    initial begin
        m = '0;
        rst_n = 1'b0; flush = 1'b0; perf_clr = 1'b0;
        instr(1'b1, AW'($urandom), AW'($urandom), AW'($urandom), 1'b1, 1'b1,
              1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'($urandom));
        @(posedge clk); #1;
        step();
        instr(1'b1, 5'd8, 5'd8, 5'd8, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'h3);
        step();
        check("reset_ex_valid", {159'd0, ex_valid}, 160'd0);
        check("reset_count", {156'd0, stall_count}, 160'd0);
        rst_n = 1'b1;
        instr(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
        step();
        check("invalid_no_regwrite", {158'd0, ex_regwrite, ex_memwrite}, 160'd0);

        // lw $8 then add $10,$8,$9: one bubble, then the add enters EX
        instr(1'b1, 5'd3, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'h2);
        step();
        instr(1'b1, 5'd8, 5'd9, 5'd10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h2);
        step();
        check("loaduse_stall", {159'd0, last_stall}, 160'd1);
        check("loaduse_bubble", {158'd0, ex_valid, ex_regwrite}, 160'd0);
        step();
        check("loaduse_after", {159'd0, last_stall}, 160'd0);
        check("dep_ex_rs", {155'd0, ex_rs}, 160'd8);
        check("dep_count", {156'd0, stall_count}, 160'd1);

        // lw $0 then use of $0
        instr(1'b1, 5'd3, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'h2);
        step();
        instr(1'b1, 5'd0, 5'd4, 5'd11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h2);
        step();
        check("zero_reg_no_stall", {159'd0, last_stall}, 160'd0);

        // lw $8 then rt = 8 with rt unused
        instr(1'b1, 5'd3, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'h2);
        step();
        instr(1'b1, 5'd5, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h2);
        step();
        check("unused_rt_no_stall", {159'd0, last_stall}, 160'd0);

        // Flush on top of a hazard
        instr(1'b1, 5'd3, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'h2);
        step();
        cnt_before = stall_count;
        instr(1'b1, 5'd8, 5'd9, 5'd10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h2);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_no_stall", {159'd0, last_stall}, 160'd0);
        check("flush_bubble", {159'd0, ex_valid}, 160'd0);
        check("flush_count", {156'd0, stall_count}, {156'd0, cnt_before});

        // add $9 then sub using $9: forwarded, no stall
        instr(1'b1, 5'd1, 5'd2, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h2);
        step();
        instr(1'b1, 5'd9, 5'd2, 5'd12, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h6);
        step();
        check("alu_dep_no_stall", {159'd0, last_stall}, 160'd0);
        check("alu_dep_ex_rs", {154'd0, ex_valid, ex_rs}, {154'd0, 1'b1, 5'd9});

        // lw $8 then sw $8 (rt used as store data)
        instr(1'b1, 5'd3, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'h2);
        step();
        instr(1'b1, 5'd4, 5'd8, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h2);
        step();
        check("store_after_load", {159'd0, last_stall}, 160'd1);
        step();

        // Chain of lw $8,0($8): every other cycle stalls, counter saturates
        perf_clr = 1'b1;
        instr(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        step();
        perf_clr = 1'b0;
        instr(1'b1, 5'd8, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'h2);
        for (int i = 0; i < 36; i++) step();
        check("count_saturated", {156'd0, stall_count}, 160'd15);
        if (!m.valid) step();
        perf_clr = 1'b1;
        step();
        perf_clr = 1'b0;
        check("clr_with_stall", {159'd0, last_stall}, 160'd1);
        check("clr_priority", {156'd0, stall_count}, 160'd0);

        // Reset asserted while a hazard is pending
        step();
        check("pre_reset_load_in_ex", {158'd0, ex_valid, ex_memread}, 160'd3);
        rst_n = 1'b0;
        step();
        check("reset_drops_stall", {159'd0, last_stall}, 160'd0);
        rst_n = 1'b1;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
